// File: rtl/icache_fill_ctl.sv
// Miss/fill sequencer for the direct-mapped instruction cache.
// Bursts a line in from the bus, commits tag/valid, and runs whole-cache flush.
module icache_fill_ctl #(
    parameter int LINE_WORDS = 16,
    parameter int IDX_BITS   = 4,
    parameter int TAG_BITS   = 22,
    localparam int WORD_BITS = $clog2(LINE_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss,
    input  logic [31:0]          miss_addr,
    input  logic                 flush,
    output logic                 bus_req,
    output logic [31:0]          bus_addr,
    input  logic                 bus_ack,
    input  logic                 bus_rvalid,
    input  logic [31:0]          bus_rdata,
    output logic                 data_we,
    output logic [IDX_BITS-1:0]  fill_idx,
    output logic [WORD_BITS-1:0] fill_word,
    output logic [31:0]          fill_data,
    output logic                 tag_we,
    output logic [TAG_BITS-1:0]  tag_out,
    output logic                 valid_we,
    output logic                 valid_val,
    output logic                 busy,
    output logic                 fill_done
);

    localparam int OFF_BITS = WORD_BITS + 2;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT,
        FLUSH
    } state_t;

    state_t                state, state_nx;
    logic [TAG_BITS-1:0]   tag_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic [WORD_BITS-1:0]  cnt;
    logic [IDX_BITS-1:0]   fidx;
    logic                  flush_pend;

    logic [TAG_BITS-1:0]   miss_tag;
    logic [IDX_BITS-1:0]   miss_idx;
    logic                  flush_go;
    logic                  unused_off;

    assign miss_tag   = miss_addr[31 -: TAG_BITS];
    assign miss_idx   = miss_addr[OFF_BITS +: IDX_BITS];
    assign unused_off = ^miss_addr[OFF_BITS-1:0];
    assign flush_go   = flush || flush_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tag_q      <= '0;
            idx_q      <= '0;
            cnt        <= '0;
            fidx       <= '0;
            flush_pend <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && !flush_go && miss) begin
                tag_q <= miss_tag;
                idx_q <= miss_idx;
            end
            // IDLE either consumes the pending flush or has none to keep
            if (state == IDLE)
                flush_pend <= 1'b0;
            else if (state != FLUSH && flush)
                flush_pend <= 1'b1;
            if (state == REQ)
                cnt <= '0;
            else if (state == FILL && bus_rvalid)
                cnt <= cnt + 1'b1;
            if (state == FLUSH)
                fidx <= fidx + 1'b1;
            else
                fidx <= '0;
        end
    end

    always_comb begin
        state_nx  = state;
        bus_req   = 1'b0;
        bus_addr  = '0;
        data_we   = 1'b0;
        fill_idx  = '0;
        fill_word = '0;
        fill_data = '0;
        tag_we    = 1'b0;
        tag_out   = '0;
        valid_we  = 1'b0;
        valid_val = 1'b0;
        fill_done = 1'b0;
        busy      = 1'b0;
        if (rst) begin
            state_nx = IDLE;
        end else begin
            busy = (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (flush_go) begin
                        state_nx = FLUSH;
                    end else if (miss) begin
                        valid_we = 1'b1;
                        fill_idx = miss_idx;
                        state_nx = REQ;
                    end
                end
                REQ: begin
                    bus_req  = 1'b1;
                    bus_addr = {tag_q, idx_q, {OFF_BITS{1'b0}}};
                    if (bus_ack)
                        state_nx = FILL;
                end
                FILL: begin
                    fill_idx = idx_q;
                    if (bus_rvalid) begin
                        data_we   = 1'b1;
                        fill_word = cnt;
                        fill_data = bus_rdata;
                        if (&cnt)
                            state_nx = COMMIT;
                    end
                end
                COMMIT: begin
                    fill_idx  = idx_q;
                    tag_we    = 1'b1;
                    tag_out   = tag_q;
                    valid_we  = 1'b1;
                    valid_val = 1'b1;
                    fill_done = 1'b1;
                    state_nx  = IDLE;
                end
                FLUSH: begin
                    fill_idx = fidx;
                    valid_we = 1'b1;
                    if (&fidx)
                        state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_fill_ctl.sv
// Directed bench for icache_fill_ctl.
// Inputs change on the falling edge; outputs are checked 1 ns later.
module tb_icache_fill_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic [31:0] miss_addr;
    logic        flush;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        data_we;
    logic [3:0]  fill_idx;
    logic [3:0]  fill_word;
    logic [31:0] fill_data;
    logic        tag_we;
    logic [21:0] tag_out;
    logic        valid_we;
    logic        valid_val;
    logic        busy;
    logic        fill_done;

    int checks = 0;
    int errors = 0;

    icache_fill_ctl dut (
        .clk(clk), .rst(rst), .miss(miss), .miss_addr(miss_addr),
        .flush(flush), .bus_req(bus_req), .bus_addr(bus_addr),
        .bus_ack(bus_ack), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .data_we(data_we), .fill_idx(fill_idx), .fill_word(fill_word),
        .fill_data(fill_data), .tag_we(tag_we), .tag_out(tag_out),
        .valid_we(valid_we), .valid_val(valid_val), .busy(busy),
        .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; miss = 1'b1; miss_addr = 32'h0000_1A4C;
        flush = 1'b0; bus_ack = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            checks++;
            if ({busy, bus_req, data_we, tag_we, valid_we, fill_done} !== 6'b0) begin
                errors++;
                $display("FAIL reset_out cyc=%0d got=%b want=000000", i,
                         {busy, bus_req, data_we, tag_we, valid_we, fill_done});
            end
        end
        tick(); rst = 1'b0; miss = 1'b0;
    endtask

    task automatic test_basic;
        tick(); miss = 1'b1; miss_addr = 32'h0000_1A4C; #1;
        checks++;
        if ({valid_we, valid_val, fill_idx, busy} !== {2'b10, 4'd9, 1'b0}) begin
            errors++;
            $display("FAIL basic_vclr we/val/idx/busy=%b/%b/%0d/%b want 1/0/9/0",
                     valid_we, valid_val, fill_idx, busy);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); miss = 1'b0; miss_addr = 32'hFFFF_FFFF; bus_ack = (i == 2); #1;
            checks++;
            if ({bus_req, busy, bus_addr} !== {2'b11, 32'h0000_1A40}) begin
                errors++;
                $display("FAIL basic_req cyc=%0d req=%b addr=%h want 1/00001a40",
                         i, bus_req, bus_addr);
            end
        end
        for (int n = 0; n < 16; n++) begin
            tick(); bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h100 + n; #1;
            checks++;
            if ({data_we, tag_we, fill_done, fill_word, fill_idx, fill_data} !==
                {3'b100, 4'(n), 4'd9, 32'h100 + n}) begin
                errors++;
                $display("FAIL basic_beat n=%0d we=%b word=%0d idx=%0d data=%h td=%b%b",
                         n, data_we, fill_word, fill_idx, fill_data, tag_we, fill_done);
            end
        end
        tick(); bus_rvalid = 1'b0; #1;
        checks++;
        if ({tag_we, valid_we, valid_val, fill_done, tag_out, fill_idx} !==
            {4'b1111, 22'h6, 4'd9}) begin
            errors++;
            $display("FAIL basic_commit tw/vw/vv/fd=%b%b%b%b tag=%h idx=%0d want 1111/6/9",
                     tag_we, valid_we, valid_val, fill_done, tag_out, fill_idx);
        end
        tick(); #1;
        checks++;
        if ({busy, fill_done, tag_we} !== 3'b0) begin
            errors++;
            $display("FAIL basic_idle busy/fd/tw=%b%b%b want 000", busy, fill_done, tag_we);
        end
    endtask

    task automatic test_gapped;
        tick(); miss = 1'b1; miss_addr = 32'h0000_2380;
        tick(); miss = 1'b0; bus_ack = 1'b1; #1;
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h0000_2380}) begin
            errors++;
            $display("FAIL gap_req req=%b addr=%h want 1/00002380", bus_req, bus_addr);
        end
        for (int n = 0; n < 16; n++) begin
            tick(); bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hA000 + n; #1;
            checks++;
            if ({data_we, fill_word, fill_idx, fill_data} !== {1'b1, 4'(n), 4'd14, 32'hA000 + n}) begin
                errors++;
                $display("FAIL gap_beat n=%0d we=%b word=%0d idx=%0d data=%h",
                         n, data_we, fill_word, fill_idx, fill_data);
            end
            tick(); bus_rvalid = 1'b0; bus_rdata = 32'hDEAD_BEEF; #1;
            checks++;
            if ({data_we, tag_we, fill_done} !== {1'b0, (n == 15), (n == 15)}) begin
                errors++;
                $display("FAIL gap_hole n=%0d we/tw/fd=%b%b%b want 0%b%b",
                         n, data_we, tag_we, fill_done, n == 15, n == 15);
            end
        end
        checks++;
        if (tag_out !== 22'h8) begin
            errors++;
            $display("FAIL gap_tag got=%h want=8", tag_out);
        end
    endtask

    task automatic test_flush_mid_fill;
        tick(); miss = 1'b1; miss_addr = 32'h0000_0040;
        tick(); miss = 1'b0; bus_ack = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick(); bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = n; flush = (n == 5);
        end
        tick(); bus_rvalid = 1'b0; flush = 1'b0; #1;
        checks++;
        if ({tag_we, fill_done, fill_idx} !== {2'b11, 4'd1}) begin
            errors++;
            $display("FAIL flush_commit tw/fd=%b%b idx=%0d want 11/1", tag_we, fill_done, fill_idx);
        end
        tick(); #1;
        checks++;
        if ({busy, valid_we} !== 2'b00) begin
            errors++;
            $display("FAIL flush_gap busy/vw=%b%b want 00", busy, valid_we);
        end
        for (int i = 0; i < 16; i++) begin
            tick(); #1;
            checks++;
            if ({busy, valid_we, valid_val, fill_idx, data_we} !== {3'b110, 4'(i), 1'b0}) begin
                errors++;
                $display("FAIL flush_step i=%0d busy/vw/vv=%b%b%b idx=%0d we=%b",
                         i, busy, valid_we, valid_val, fill_idx, data_we);
            end
        end
        tick(); #1;
        checks++;
        if ({busy, valid_we} !== 2'b00) begin
            errors++;
            $display("FAIL flush_end busy/vw=%b%b want 00", busy, valid_we);
        end
    endtask

    task automatic test_reset_mid_fill;
        tick(); miss = 1'b1; miss_addr = 32'h0000_1A4C;
        tick(); miss = 1'b0; bus_ack = 1'b1;
        for (int n = 0; n < 9; n++) begin
            tick(); bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = n; rst = (n == 8);
        end
        tick(); rst = 1'b0; bus_rvalid = 1'b0; #1;
        checks++;
        if ({busy, bus_req, tag_we, fill_done, data_we} !== 5'b0) begin
            errors++;
            $display("FAIL rstfill_abort got=%b want 00000",
                     {busy, bus_req, tag_we, fill_done, data_we});
        end
        miss = 1'b1; #1;
        checks++;
        if ({valid_we, valid_val, fill_idx} !== {2'b10, 4'd9}) begin
            errors++;
            $display("FAIL rstfill_vclr vw/vv=%b%b idx=%0d want 10/9", valid_we, valid_val, fill_idx);
        end
        tick(); miss = 1'b0; bus_ack = 1'b1;
        tick(); bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55; #1;
        checks++;
        if ({data_we, fill_word, fill_data} !== {1'b1, 4'd0, 32'h55}) begin
            errors++;
            $display("FAIL rstfill_restart we=%b word=%0d data=%h want 1/0/55",
                     data_we, fill_word, fill_data);
        end
        for (int n = 1; n < 16; n++) begin
            tick(); bus_rdata = n;
        end
        tick(); bus_rvalid = 1'b0; #1;
        checks++;
        if ({fill_done, tag_out} !== {1'b1, 22'h6}) begin
            errors++;
            $display("FAIL rstfill_commit fd=%b tag=%h want 1/6", fill_done, tag_out);
        end
    endtask

    task automatic test_stray_and_busy_miss;
        tick(); bus_rvalid = 1'b1; bus_rdata = 32'hBAD; #1;
        checks++;
        if ({data_we, busy, valid_we} !== 3'b0) begin
            errors++;
            $display("FAIL stray_idle we/busy/vw=%b%b%b want 000", data_we, busy, valid_we);
        end
        tick(); bus_rvalid = 1'b0; miss = 1'b1; miss_addr = 32'h0000_1A4C;
        tick(); miss_addr = 32'h0000_3A4C; bus_ack = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick(); bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = n; #1;
            checks++;
            if ({valid_we, bus_req, data_we, fill_word} !== {3'b001, 4'(n)}) begin
                errors++;
                $display("FAIL busy_miss n=%0d vw/req/we=%b%b%b word=%0d",
                         n, valid_we, bus_req, data_we, fill_word);
            end
        end
        tick(); bus_rvalid = 1'b0; #1;
        checks++;
        if ({fill_done, tag_out} !== {1'b1, 22'h6}) begin
            errors++;
            $display("FAIL busy_commit1 fd=%b tag=%h want 1/6", fill_done, tag_out);
        end
        tick(); #1;
        checks++;
        if ({valid_we, valid_val, fill_idx} !== {2'b10, 4'd9}) begin
            errors++;
            $display("FAIL evict_vclr vw/vv=%b%b idx=%0d want 10/9", valid_we, valid_val, fill_idx);
        end
        tick(); miss = 1'b0; bus_ack = 1'b1; #1;
        checks++;
        if ({bus_req, bus_addr} !== {1'b1, 32'h0000_3A40}) begin
            errors++;
            $display("FAIL evict_req req=%b addr=%h want 1/00003a40", bus_req, bus_addr);
        end
        for (int n = 0; n < 16; n++) begin
            tick(); bus_ack = 1'b0; bus_rvalid = 1'b1; bus_rdata = n;
        end
        tick(); bus_rvalid = 1'b0; #1;
        checks++;
        if ({fill_done, tag_out, fill_idx} !== {1'b1, 22'hE, 4'd9}) begin
            errors++;
            $display("FAIL evict_commit fd=%b tag=%h idx=%0d want 1/e/9", fill_done, tag_out, fill_idx);
        end
        tick(); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_flush_mid_fill();
        test_reset_mid_fill();
        test_stray_and_busy_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
